// File: rtl/skel_pkg.sv
// Skeletonization pass scheduler shared types.
// State encoding plus image and pass sizing helpers.
package skel_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SCAN,
    WAIT,
    WB,
    CHECK,
    DONE
  } state_t;

  function automatic int pix_count(input int n);
    return n * n;
  endfunction

  function automatic int pass_w(input int max_passes);
    return $clog2(max_passes + 1);
  endfunction

endpackage

// File: rtl/skel_addr_counter.sv
// Pixel address counter with clear, enable and terminal flag.
// Used both for the load index and for the scan centre.
module skel_addr_counter #(
  parameter int W    = 6,
  parameter int LAST = 63
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         last
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign last = (cnt == W'(LAST));

endmodule

// File: rtl/skel_pass_scheduler.sv
// Load / scan / writeback sequencer for the thinning kernel.
// Ping-pongs between two image banks until a pass is stable.
module skel_pass_scheduler
  import skel_pkg::*;
#(
  parameter int N          = 8,
  parameter int pixelWidth = 8,
  parameter int MAX_PASSES = 16,
  localparam int bitSize   = $clog2(pix_count(N)),
  localparam int PW        = pass_w(MAX_PASSES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [pixelWidth-1:0] data_in,
  output logic                  load_ready,
  output logic                  ram_we,
  output logic [bitSize-1:0]    ram_addr,
  output logic [pixelWidth-1:0] ram_wdata,
  output logic                  rd_bank,
  output logic                  kern_start,
  output logic [bitSize-1:0]    kern_center,
  input  logic                  kern_done,
  input  logic [pixelWidth-1:0] kern_pixel,
  input  logic                  kern_changed,
  output logic                  busy,
  output logic                  done,
  output logic [PW-1:0]         pass_count
);

  state_t             state;
  logic               changed;
  logic               accept;
  logic [bitSize-1:0] load_cnt;
  logic [bitSize-1:0] c;
  logic               load_last;
  logic               c_last;
  logic               load_en;
  logic               load_clr;
  logic               c_en;
  logic               c_clr;
  logic [PW-1:0]      pass_next;

  assign load_ready = state inside {IDLE, LOAD, DONE};
  assign busy       = state inside {LOAD, SCAN, WAIT, WB, CHECK};
  assign done       = (state == DONE);
  assign accept     = we & load_ready;
  assign kern_center = c;
  assign pass_next  = pass_count + 1'b1;

  assign load_en  = accept & ~load_last;
  assign load_clr = accept & load_last;
  assign c_en     = (state == WB) & ~c_last;
  assign c_clr    = (state == WB) & c_last;

  skel_addr_counter #(
    .W    (bitSize),
    .LAST (pix_count(N) - 1)
  ) u_load_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (load_clr),
    .en    (load_en),
    .cnt   (load_cnt),
    .last  (load_last)
  );

  skel_addr_counter #(
    .W    (bitSize),
    .LAST (pix_count(N) - 1)
  ) u_center_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (c_clr),
    .en    (c_en),
    .cnt   (c),
    .last  (c_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      rd_bank    <= 1'b0;
      kern_start <= 1'b0;
      changed    <= 1'b0;
      pass_count <= '0;
    end else begin
      ram_we     <= 1'b0;
      kern_start <= 1'b0;
      unique case (state)
        IDLE, LOAD, DONE: begin
          if (accept) begin
            ram_we    <= 1'b1;
            ram_addr  <= load_cnt;
            ram_wdata <= data_in;
            if (state == DONE) begin
              pass_count <= '0;
              rd_bank    <= 1'b0;
            end
            // last pixel write overlaps the first kernel request
            if (load_last) begin
              state      <= SCAN;
              kern_start <= 1'b1;
              changed    <= 1'b0;
            end else begin
              state <= LOAD;
            end
          end
        end
        SCAN: state <= WAIT;
        WAIT: begin
          if (kern_done) begin
            ram_we    <= 1'b1;
            ram_addr  <= c;
            ram_wdata <= kern_pixel;
            changed   <= changed | kern_changed;
            state     <= WB;
          end
        end
        WB: begin
          if (c_last) begin
            state <= CHECK;
          end else begin
            state      <= SCAN;
            kern_start <= 1'b1;
          end
        end
        CHECK: begin
          pass_count <= pass_next;
          rd_bank    <= ~rd_bank;
          if (changed && (pass_next < PW'(MAX_PASSES))) begin
            state      <= SCAN;
            kern_start <= 1'b1;
            changed    <= 1'b0;
          end else begin
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_skel_pass_scheduler.sv
// Directed bench for skel_pass_scheduler.
// Scenario table plus reset and stray-input sequences.
module tb_skel_pass_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       we;
  logic [7:0] data_in;
  logic       load_ready;
  logic       ram_we;
  logic [5:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       rd_bank;
  logic       kern_start;
  logic [5:0] kern_center;
  logic       kern_done;
  logic [7:0] kern_pixel;
  logic       kern_changed;
  logic       busy;
  logic       done;
  logic [4:0] pass_count;

  skel_pass_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .we           (we),
    .data_in      (data_in),
    .load_ready   (load_ready),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .rd_bank      (rd_bank),
    .kern_start   (kern_start),
    .kern_center  (kern_center),
    .kern_done    (kern_done),
    .kern_pixel   (kern_pixel),
    .kern_changed (kern_changed),
    .busy         (busy),
    .done         (done),
    .pass_count   (pass_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int gaps;
    int kdelay;
    int stray;
    int chg;
    int exp_pass;
    int exp_bank;
    int exp_wr;
    int exp_kst;
  } vec_t;

  vec_t vecs[5];

  int n_chk  = 0;
  int n_fail = 0;

  int kdelay = 1;
  int stray  = 0;
  int chg    = 0;
  int kst      = 0;
  int kst_base = 0;
  int cen_err  = 0;
  int wr       = 0;
  int wr_base  = 0;
  int wr_err   = 0;
  int hand     = 0;

  function automatic logic [7:0] img(input int k);
    return 8'((k * 37 + 5) & 255);
  endfunction

  function automatic logic [7:0] kpix(input int cc, input int p);
    return 8'((cc * 3 + p) & 255);
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Kernel model: answers each request after kdelay cycles
  initial begin
    int cen;
    int p;
    kern_done    = 1'b0;
    kern_pixel   = 8'h00;
    kern_changed = 1'b0;
    forever begin
      @(negedge clk);
      if (kern_start === 1'b1) begin
        cen = int'(kern_center);
        p   = (kst - kst_base) / 64 + 1;
        kst++;
        if (stray != 0) begin
          kern_done    = 1'b1;
          kern_changed = 1'b1;
        end
        repeat (kdelay) begin
          @(posedge clk);
          #1;
          kern_done    = 1'b0;
          kern_changed = 1'b0;
          if (int'(kern_center) != cen) cen_err++;
        end
        kern_done    = 1'b1;
        kern_pixel   = kpix(cen, p);
        kern_changed = (p <= chg);
        @(posedge clk);
        #1;
        kern_done    = 1'b0;
        kern_changed = 1'b0;
        if (stray != 0) begin
          kern_done    = 1'b1;
          kern_changed = 1'b1;
          @(posedge clk);
          #1;
          kern_done    = 1'b0;
          kern_changed = 1'b0;
        end
      end
    end
  end

  // Write monitor: expected address, data and bank per write index
  int m_idx;
  int m_j;
  int m_p;
  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      m_idx = wr - wr_base;
      if (m_idx < 64) begin
        if (int'(ram_addr) != m_idx || ram_wdata !== img(m_idx)
            || rd_bank !== 1'b0)
          wr_err++;
        if (m_idx == 63 && kern_start === 1'b1) hand++;
      end else begin
        m_j = m_idx - 64;
        m_p = m_j / 64 + 1;
        if (int'(ram_addr) != (m_j % 64)
            || ram_wdata !== kpix(m_j % 64, m_p)
            || rd_bank !== 1'(((m_p - 1) & 1)))
          wr_err++;
      end
      wr++;
    end
  end

  task automatic check_reset(input string t);
    chk({t, ".load_ready"}, 32'(load_ready), 1);
    chk({t, ".busy"}, 32'(busy), 0);
    chk({t, ".done"}, 32'(done), 0);
    chk({t, ".ram_we"}, 32'(ram_we), 0);
    chk({t, ".kern_start"}, 32'(kern_start), 0);
    chk({t, ".pass_count"}, 32'(pass_count), 0);
    chk({t, ".rd_bank"}, 32'(rd_bank), 0);
    chk({t, ".kern_center"}, 32'(kern_center), 0);
    chk({t, ".ram_addr"}, 32'(ram_addr), 0);
  endtask

  task automatic load_image(input int gaps);
    for (int k = 0; k < 64; k++) begin
      we      = 1'b1;
      data_in = img(k);
      @(posedge clk);
      #1;
      if (gaps != 0) begin
        we      = 1'b0;
        data_in = 8'hEE;
        @(posedge clk);
        #1;
      end
    end
    we = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string t);
    int cyc;
    int e0;
    int c0;
    int h0;
    int w1;
    kdelay   = v.kdelay;
    stray    = v.stray;
    chg      = v.chg;
    wr_base  = wr;
    kst_base = kst;
    e0 = wr_err;
    c0 = cen_err;
    h0 = hand;
    load_image(v.gaps);
    cyc = 0;
    while (done !== 1'b1 && cyc < 20000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({t, ".done"}, 32'(done), 1);
    w1 = wr;
    repeat (3) @(posedge clk);
    #1;
    chk({t, ".done_hold"}, 32'(done), 1);
    chk({t, ".busy"}, 32'(busy), 0);
    chk({t, ".pass_count"}, 32'(pass_count), 32'(v.exp_pass));
    chk({t, ".rd_bank"}, 32'(rd_bank), 32'(v.exp_bank));
    chk({t, ".writes"}, 32'(wr - wr_base), 32'(v.exp_wr));
    chk({t, ".idle_writes"}, 32'(wr - w1), 0);
    chk({t, ".kern_starts"}, 32'(kst - kst_base), 32'(v.exp_kst));
    chk({t, ".write_errs"}, 32'(wr_err - e0), 0);
    chk({t, ".center_moves"}, 32'(cen_err - c0), 0);
    chk({t, ".handoff"}, 32'(hand - h0), 1);
  endtask

  initial begin
    int cyc;
    int w0;
    vec_t rv;
    vecs[0] = '{0, 1, 0, 0,  1,  1, 128,  64};
    vecs[1] = '{0, 1, 0, 2,  3,  1, 256,  192};
    vecs[2] = '{0, 1, 0, 99, 16, 0, 1088, 1024};
    vecs[3] = '{1, 5, 1, 0,  1,  1, 128,  64};
    vecs[4] = '{1, 2, 1, 1,  2,  0, 192,  128};
    rv      = '{0, 1, 0, 0,  1,  1, 128,  64};

    rst_n   = 1'b0;
    we      = 1'b0;
    data_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle.load_ready", 32'(load_ready), 1);
    chk("idle.ram_we", 32'(ram_we), 0);

    for (int i = 0; i < 5; i++)
      run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset during pass 2 with a stray we in SCAN
    kdelay   = 5;
    stray    = 0;
    chg      = 99;
    wr_base  = wr;
    kst_base = kst;
    load_image(0);
    cyc = 0;
    while (pass_count !== 5'd1 && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("mid.reach_pass2", 32'(pass_count), 1);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (kern_start !== 1'b1 && cyc < 100);
    chk("mid.scan_seen", 32'(kern_start), 1);
    we      = 1'b1;
    data_in = 8'hAA;
    @(negedge clk);
    chk("mid.stray_we1", 32'(ram_we), 0);
    @(negedge clk);
    chk("mid.stray_we2", 32'(ram_we), 0);
    we    = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_reset("midrst");
    w0 = wr;
    repeat (10) @(posedge clk);
    #1;
    chk("midrst.no_writes", 32'(wr - w0), 0);
    chk("midrst.idle", 32'(busy), 0);

    run_vec(rv, "reload");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
